// File: rtl/fetch_queue_if.sv
// fetch_queue_if: IF->ID handshake bundle for the fetch queue.
//   Push side : in_valid/in_ready/in_instr/in_pc (IF -> queue)
//   Pop side  : out_valid/out_ready/out_instr/out_pc (queue -> ID)
//   Control   : flush (redirect), count/misalign (status from queue)
//   modport master : the fetch/decode environment driving the queue
//   modport slave  : the queue itself
interface fetch_queue_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [WIDTH-1:0] out_pc;
  logic             flush;
  logic [CW-1:0]    count;
  logic             misalign;

  modport master (
    output in_valid, in_instr, in_pc, out_ready, flush,
    input  in_ready, out_valid, out_instr, out_pc, count, misalign
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready, flush,
    output in_ready, out_valid, out_instr, out_pc, count, misalign
  );
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry {instr, PC} FIFO between IF and ID.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (wins over flush and handshakes)
//   bus  : fetch_queue_if.slave
//          in_*  push side, in_ready = not full (state only)
//          out_* oldest entry, first-word fall-through; NOP/0 when empty
//          flush empties the queue in one cycle, ignoring that cycle's push/pop
//          count occupied entries, misalign sticky PC[1:0]!=0 flag
module fetch_queue #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0]   NOP    = 32'h0000_0013;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0]      instr;
    logic [WIDTH-1:0] pc;
  } entry_t;

  entry_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    wr_ptr, rd_ptr;
  logic   [CW-1:0]    cnt;
  logic               misalign_q;

  logic in_ready, out_valid, push, pop;

  assign in_ready  = (cnt != FULL_C);
  assign out_valid = (cnt != '0);
  assign push      = bus.in_valid & in_ready;
  assign pop       = out_valid & bus.out_ready;

  // Pointers are AW bits wide, so +1 wraps modulo DEPTH (power of two).
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      misalign_q <= 1'b0;
    end else if (bus.flush) begin
      // misalign is deliberately kept across redirects
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && bus.in_pc[1:0] != 2'b00) misalign_q <= 1'b1;
    end
  end

  // Storage needs no reset; contents are only observed through rd_ptr/cnt.
  always_ff @(posedge clk) begin
    if (!rst && !bus.flush && push) begin
      mem[wr_ptr].instr <= bus.in_instr;
      mem[wr_ptr].pc    <= bus.in_pc;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? mem[rd_ptr].instr : NOP;
  assign bus.out_pc    = out_valid ? mem[rd_ptr].pc    : '0;
  assign bus.count     = cnt;
  assign bus.misalign  = misalign_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard. The driver pushes
// expected {instr,pc} pairs when a push is accepted; an independent monitor
// pops and compares whenever out_valid & out_ready at the negedge.
module tb_fetch_queue;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [95:0] sb[$];   // {instr, pc}

  function automatic logic [31:0] instr_of(logic [63:0] pc);
    return 32'hA000_0000 | pc[31:0];
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one cycle starting just after a posedge; returns just after the next.
  task automatic drive(logic v, logic [63:0] pc, logic rdy, logic fl);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = instr_of(pc);
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(negedge clk);
    if (v && bus.in_ready && !fl) sb.push_back({instr_of(pc), pc});
    @(posedge clk); #1;
    if (fl) sb.delete();
  endtask

  task automatic idle(); drive(1'b0, 64'h0, 1'b0, 1'b0); endtask

  // Monitor: independent of the driver
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_unexpected actual=%0h required=none", bus.out_pc);
      end else begin
        logic [95:0] e;
        e = sb.pop_front();
        chk("out_pc",    64'(bus.out_pc),    64'(e[63:0]));
        chk("out_instr", 64'(bus.out_instr), 64'(e[95:64]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 0; bus.in_pc = '0; bus.in_instr = '0;
    bus.out_ready = 0; bus.flush = 0;
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0;

    // 1 reset state
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_in_ready",  64'(bus.in_ready),  1);
    chk("rst_count",     64'(bus.count),     0);
    chk("rst_out_instr", 64'(bus.out_instr), 64'h13);
    chk("rst_out_pc",    64'(bus.out_pc),    0);
    chk("rst_misalign",  64'(bus.misalign),  0);

    // 2 fill / drain; no same-cycle bypass into an empty queue
    bus.in_valid = 1; bus.in_pc = 64'h0; #1;
    chk("no_bypass", 64'(bus.out_valid), 0);
    drive(1, 64'h0, 0, 0);
    chk("fwft_valid", 64'(bus.out_valid), 1);
    chk("fwft_count", 64'(bus.count), 1);
    drive(1, 64'h4, 0, 0);
    drive(1, 64'h8, 0, 0);
    drive(1, 64'hC, 0, 0);
    chk("full_count",    64'(bus.count), 4);
    chk("full_in_ready", 64'(bus.in_ready), 0);
    chk("full_head_pc",  64'(bus.out_pc), 0);
    for (int i = 0; i < 4; i++) drive(0, 64'h0, 1, 0);
    chk("drain_count",  64'(bus.count), 0);
    chk("drain_nop",    64'(bus.out_instr), 64'h13);
    chk("drain_pc0",    64'(bus.out_pc), 0);
    chk("aligned_no_misalign", 64'(bus.misalign), 0);

    // 3 simultaneous push/pop at count=2 across pointer wrap
    drive(1, 64'h10, 0, 0);
    drive(1, 64'h14, 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 64'h18 + 64'(4 * i), 1, 0);
      chk("simul_count", 64'(bus.count), 2);
    end
    drive(0, 64'h0, 1, 0);
    drive(0, 64'h0, 1, 0);
    chk("simul_drained", 64'(bus.count), 0);

    // 4 full + pop: push refused that cycle, accepted the next
    drive(1, 64'h40, 0, 0);
    drive(1, 64'h44, 0, 0);
    drive(1, 64'h48, 0, 0);
    drive(1, 64'h4C, 0, 0);
    drive(1, 64'h50, 1, 0);
    chk("fullpop_count", 64'(bus.count), 3);
    chk("fullpop_ready", 64'(bus.in_ready), 1);
    drive(1, 64'h50, 0, 0);
    chk("fullpop_refill", 64'(bus.count), 4);
    for (int i = 0; i < 4; i++) drive(0, 64'h0, 1, 0);
    chk("fullpop_drained", 64'(bus.count), 0);

    // 5 flush with a push and pop in the same cycle
    drive(1, 64'h60, 0, 0);
    drive(1, 64'h64, 0, 0);
    drive(1, 64'h68, 0, 0);
    chk("pre_flush_count", 64'(bus.count), 3);
    drive(1, 64'h6C, 1, 1);
    chk("flush_count", 64'(bus.count), 0);
    chk("flush_valid", 64'(bus.out_valid), 0);
    chk("flush_pc",    64'(bus.out_pc), 0);
    drive(0, 64'h0, 0, 1);   // flush while empty
    chk("flush_empty_count", 64'(bus.count), 0);
    drive(1, 64'h100, 0, 0);
    chk("post_flush_head", 64'(bus.out_pc), 64'h100);
    drive(0, 64'h0, 1, 0);

    // 6 misalign: sticky, survives flush, cleared by reset
    chk("misalign_before", 64'(bus.misalign), 0);
    drive(1, 64'h102, 0, 0);
    chk("misalign_set",   64'(bus.misalign), 1);
    chk("misalign_queued", 64'(bus.count), 1);
    drive(0, 64'h0, 1, 0);
    drive(1, 64'h203, 0, 1);  // misaligned push discarded by flush
    chk("misalign_flush", 64'(bus.misalign), 1);
    chk("misalign_flush_count", 64'(bus.count), 0);
    rst = 1; bus.in_valid = 1; bus.in_pc = 64'h300; bus.flush = 1;
    @(posedge clk); #1;
    rst = 0; bus.in_valid = 0; bus.flush = 0;
    chk("misalign_rst", 64'(bus.misalign), 0);
    chk("rst_over_push", 64'(bus.count), 0);
    idle();

    chk("sb_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
